// File: rtl/lcd_string_driver.sv
// lcd_string_driver: HD44780 4-bit power-up init plus continuous redraw of a 2x16 text buffer.
module lcd_string_driver #(
  parameter int US_CYCLES = 50,
  parameter int E_CYCLES  = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refresh,
  input  logic [255:0] text,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [3:0]   lcd_d,
  output logic         ready
);
  localparam int WMAX = 15000 * US_CYCLES;
  localparam int CW = $clog2(WMAX + 1);
  localparam logic [3:0] INIT_NIB [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
  localparam int INIT_GAP [12] = '{4100, 100, 40, 40, 1, 40, 1, 40, 1, 40, 1, 1640};
  typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, FRAME} state_t;
  typedef enum logic [1:0] {SETUP, STROBE, HOLD, GAP} phase_t;
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d, gap_cyc;
  logic [3:0] nib_q, nib_d, nib_val;
  logic [5:0] idx_q, idx_d;
  logic half_q, half_d, pend_q, pend_d;
  logic [255:0] snap_q, snap_d;
  logic [4:0] pos;
  logic [7:0] byte_val;
  logic active, rs_val, set, done_seq, start;
  int gap_us;
  always_comb begin
    pos = idx_q < 6'd17 ? 5'(idx_q - 6'd1) : 5'(idx_q - 6'd2);
    byte_val = idx_q == 6'd0 ? 8'h80 : idx_q == 6'd17 ? 8'hC0 : snap_q[{~pos, 3'b000} +: 8];
    nib_val = state_q == INIT ? INIT_NIB[nib_q] : half_q ? byte_val[3:0] : byte_val[7:4];
    rs_val = state_q == FRAME && idx_q != 6'd0 && idx_q != 6'd17;
    gap_us = state_q == INIT ? INIT_GAP[nib_q] : half_q ? 40 : 1;
    gap_cyc = CW'(gap_us * US_CYCLES - 1);
    active = state_q == INIT || state_q == FRAME;
  end
  assign lcd_e = active && phase_q == STROBE;
  assign lcd_d = active ? nib_val : 4'h0;
  assign lcd_rs = rs_val;
  assign lcd_rw = 1'b0;
  assign ready = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    nib_d = nib_q;
    idx_d = idx_q;
    half_d = half_q;
    pend_d = pend_q;
    snap_d = snap_q;
    start = 1'b0;
    set = refresh && state_q != IDLE;
    done_seq = state_q == INIT ? nib_q == 4'd11 : half_q && idx_q == 6'd33;
    if (state_q == IDLE) begin
      start = refresh || pend_q;
    end else begin
      pend_d = pend_q | set;
      if (state_q == PWR_WAIT) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = INIT;
          phase_d = SETUP;
          cnt_d = CW'(1);
          nib_d = 4'd0;
        end
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (phase_q != GAP) begin
        phase_d = phase_q == SETUP ? STROBE : phase_q == STROBE ? HOLD : GAP;
        cnt_d = phase_q == SETUP ? CW'(E_CYCLES - 1) : phase_q == STROBE ? '0 : gap_cyc;
      end else if (done_seq) begin
        // A pending request chains straight into the next frame without a ready pulse.
        if (pend_q) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          pend_d = state_q == INIT || set;
        end
      end else begin
        phase_d = SETUP;
        cnt_d = CW'(1);
        nib_d = state_q == INIT ? nib_q + 4'd1 : nib_q;
        half_d = state_q == FRAME ? ~half_q : half_q;
        idx_d = state_q == FRAME && half_q && idx_q != 6'd33 ? idx_q + 6'd1 : idx_q;
      end
    end
    if (start) begin
      state_d = FRAME;
      phase_d = SETUP;
      cnt_d = CW'(1);
      idx_d = 6'd0;
      half_d = 1'b0;
      pend_d = 1'b0;
      snap_d = text;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      phase_q <= SETUP;
      cnt_q <= CW'(WMAX - 1);
      nib_q <= 4'd0;
      idx_q <= 6'd0;
      half_q <= 1'b0;
      pend_q <= 1'b0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      nib_q <= nib_d;
      idx_q <= idx_d;
      half_q <= half_d;
      pend_q <= pend_d;
      snap_q <= snap_d;
    end
  end
endmodule

// File: tb/tb_lcd_string_driver.sv
// tb_lcd_string_driver: nibble-queue reference model checked every cycle, plus literal spot checks.
module tb_lcd_string_driver;
  localparam int E = 2;
  localparam int PW = 15000;
  logic clk = 0, rst = 1, refresh = 0;
  logic [255:0] text;
  logic lcd_rs, lcd_rw, lcd_e, ready;
  logic [3:0] lcd_d;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  lcd_string_driver #(.US_CYCLES(1), .E_CYCLES(E)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .text(text),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d), .ready(ready)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  typedef struct {bit rs; bit [3:0] d; int gap;} nib_t;
  nib_t mq[$];
  int mode, pwr, pos;
  bit mpend, in_init, mset;
  function automatic void push_byte(bit rs, bit [7:0] b, int g);
    mq.push_back('{rs, b[7:4], 1});
    mq.push_back('{rs, b[3:0], g});
  endfunction
  function automatic void push_init();
    mq.push_back('{0, 4'h3, 4100});
    mq.push_back('{0, 4'h3, 100});
    mq.push_back('{0, 4'h3, 40});
    mq.push_back('{0, 4'h2, 40});
    push_byte(0, 8'h28, 40);
    push_byte(0, 8'h06, 40);
    push_byte(0, 8'h0C, 40);
    push_byte(0, 8'h01, 1640);
  endfunction
  function automatic void push_frame(bit [255:0] t);
    push_byte(0, 8'h80, 40);
    for (int i = 0; i < 16; i++) push_byte(1, t[255-8*i -: 8], 40);
    push_byte(0, 8'hC0, 40);
    for (int i = 0; i < 16; i++) push_byte(1, t[127-8*i -: 8], 40);
  endfunction
  // mode: 0 power-up wait, 1 writing nibbles from mq, 2 idle
  always @(posedge clk) begin
    if (rst) begin
      mode = 0; pwr = PW; pos = 0; mpend = 0; in_init = 0;
      mq.delete();
    end else begin
      mset = refresh && mode != 2;
      if (mode == 0) begin
        mpend |= mset;
        pwr--;
        if (pwr == 0) begin mode = 1; in_init = 1; pos = 0; push_init(); end
      end else if (mode == 1) begin
        pos++;
        if (pos == 3 + E + mq[0].gap) begin
          void'(mq.pop_front());
          pos = 0;
        end
        if (pos == 0 && mq.size() == 0) begin
          if (mpend) begin mpend = 0; in_init = 0; push_frame(text); end
          else begin mode = 2; mpend = in_init | mset; end
        end else mpend |= mset;
      end else if (refresh || mpend) begin
        mpend = 0; mode = 1; in_init = 0; pos = 0; push_frame(text);
      end
    end
  end
  logic [4:0] nlog[$];
  bit prev_e;
  int since_rel, first_rise;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_e", lcd_e, 0); chk("rst_ready", ready, 0);
      chk("rst_rs", lcd_rs, 0); chk("rst_d", lcd_d, 0);
      since_rel = 0; first_rise = -1; prev_e = 0;
    end else begin
      chk("e", lcd_e, mode == 1 && pos >= 2 && pos < 2 + E);
      chk("ready", ready, mode == 2);
      chk("rw", lcd_rw, 0);
      if (mode == 1) begin
        chk("rs", lcd_rs, mq[0].rs);
        chk("d", lcd_d, mq[0].d);
      end
      if (lcd_e && !prev_e) begin
        nlog.push_back({lcd_rs, lcd_d});
        if (first_rise < 0) first_rise = since_rel;
      end
      prev_e = lcd_e;
      since_rel++;
    end
  end
  task automatic cyc();
    @(posedge clk); #2;
  endtask
  task automatic pulse();
    refresh = 1; cyc(); refresh = 0;
  endtask
  task automatic wait_ready(input string name, input int max);
    int n = 0;
    while (ready !== 1'b1 && n < max) begin cyc(); n++; end
    chk(name, ready, 1);
  endtask
  task automatic wait_log(input string name, input int cnt);
    int n = 0;
    while (nlog.size() < cnt && n < 5000) begin cyc(); n++; end
    chk(name, nlog.size() >= cnt, 1);
  endtask
  function automatic logic [8:0] byte_at(int i);
    return {nlog[2*i][4], nlog[2*i][3:0], nlog[2*i+1][3:0]};
  endfunction
  function automatic logic [255:0] rnd_text();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
    return t;
  endfunction
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] init_exp [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    logic [255:0] t1, t2;
    logic [7:0] eb;
    int hdr;
    t1 = {"1234567812345678", "8765432187654321"};
    text = t1;
    repeat (3) cyc();
    chk("reset_ready", ready, 0);
    chk("reset_e", lcd_e, 0);
    rst = 0;
    wait_ready("init_ready", 25000);
    chk("first_rise", first_rise, 15002);
    for (int i = 0; i < 12; i++) chk("init_nibble", nlog[i], {1'b0, init_exp[i]});
    cyc();
    chk("auto_start", ready, 0);
    wait_ready("auto_frame_done", 3000);
    nlog.delete();
    pulse();
    chk("ready_fall", ready, 0);
    wait_ready("frame1_done", 3000);
    chk("frame1_len", nlog.size(), 68);
    for (int i = 0; i < 34 && 2 * i + 1 < nlog.size(); i++) begin
      eb = i == 0 ? 8'h80 : i <= 8 ? 8'(8'h30 + i) : i <= 16 ? 8'(8'h30 + i - 8) :
           i == 17 ? 8'hC0 : i <= 25 ? 8'(8'h39 - (i - 17)) : 8'(8'h39 - (i - 25));
      chk("frame1_byte", byte_at(i), {i != 0 && i != 17, eb});
    end
    t2 = rnd_text();
    nlog.delete();
    pulse();
    wait_log("reach_idx5", 11);
    text = t2;
    wait_ready("frame2_done", 3000);
    chk("old_text_kept", byte_at(20), {1'b1, 8'h36});
    nlog.delete();
    pulse();
    wait_ready("frame3_done", 3000);
    chk("new_text_shown", byte_at(20), {1'b1, t2[111:104]});
    nlog.delete();
    pulse();
    wait_log("frame4_started", 4);
    pulse();
    repeat (50) cyc();
    pulse();
    repeat (300) cyc();
    pulse();
    wait_ready("pending_done", 5000);
    hdr = 0;
    for (int i = 0; 2 * i + 1 < nlog.size(); i++) if (byte_at(i) == 9'h080) hdr++;
    chk("pending_frames", hdr, 2);
    chk("pending_len", nlog.size(), 136);
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 199) == 0) text = rnd_text();
      if ($urandom_range(0, 299) == 0) pulse(); else cyc();
    end
    wait_ready("random_done", 5000);
    nlog.delete();
    pulse();
    wait_log("reach_idx20", 41);
    chk("e_before_rst", lcd_e, 1);
    rst = 1;
    #1;
    chk("async_e", lcd_e, 0);
    chk("async_ready", ready, 0);
    repeat (3) cyc();
    nlog.delete();
    rst = 0;
    wait_ready("reinit_ready", 25000);
    chk("reinit_first_rise", first_rise, 15002);
    chk("reinit_first_nib", nlog[0], 5'h03);
    repeat (20) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_string_driver.md
LCD_STRING_DRIVER -- requirements
Module: lcd_string_driver

Interface
REQ-001 SHALL have parameter US_CYCLES, default 50, clk cycles per microsecond (sim uses 1).
REQ-002 SHALL have parameter E_CYCLES, default 12, clk cycles lcd_e is held high per nibble.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; rst is asynchronous, active-high; clock is clk.
REQ-005 SHALL have port refresh  input  1  one-cycle request to redraw the whole display.
REQ-006 SHALL have port text  input  256  32 ASCII chars; [255:248] = line 0 col 0, [135:128] = line 0 col 15, [127:120] = line 1 col 0, [7:0] = line 1 col 15.
REQ-007 SHALL have port lcd_rs  output  1  HD44780 register select (0 = command, 1 = data).
REQ-008 SHALL have port lcd_rw  output  1  read/write, constant 0.
REQ-009 SHALL have port lcd_e  output  1  enable strobe.
REQ-010 SHALL have port lcd_d  output  4  data nibble.
REQ-011 SHALL have port ready  output  1  high when init is complete and no frame is in progress.

Function
REQ-012 SHALL use 4-bit writes only: each byte is sent as high nibble, then low nibble.
REQ-013 Each nibble write SHALL follow this cycle sequence:
- lcd_rs/lcd_d driven for 2 cycles with lcd_e=0 (setup);
- lcd_e=1 for E_CYCLES cycles;
- lcd_e=0 with lcd_rs/lcd_d held for 1 cycle, then the gap wait.
REQ-014 Gap waits:
- 1 us between the two nibbles of a byte;
- 40 us after each byte, except after clear (0x01), which waits 1640 us.
REQ-015 Power-up state PWR_WAIT SHALL last 15000 us with lcd_e=0.
REQ-016 State INIT SHALL then perform the following, in order:
- single nibbles 0x3 (wait 4100 us), 0x3 (wait 100 us), 0x3 (wait 40 us), 0x2 (wait 40 us);
- bytes 0x28, 0x06, 0x0C, 0x01, all with lcd_rs=0.
REQ-017 After INIT, the block SHALL enter IDLE and raise ready, then start one frame automatically.
REQ-018 A frame SHALL be 34 byte writes:
- index 0: command 0x80 (rs=0);
- indices 1-16: line 0 chars (rs=1);
- index 17: command 0xC0 (rs=0);
- indices 18-33: line 1 chars (rs=1).
REQ-019 text SHALL be snapshotted into an internal register on the cycle a frame starts; text changes mid-frame SHALL NOT affect that frame.
REQ-020 refresh in IDLE SHALL start a frame on the next cycle; ready SHALL fall on that cycle and rise on the cycle after the final 40 us gap of index 33.
REQ-021 refresh while not IDLE (PWR_WAIT, INIT or frame) SHALL set a single pending flag; further refreshes while pending SHALL be ignored. At frame or INIT end with the flag set, a new frame SHALL start immediately (ready stays low) and the flag SHALL clear.
REQ-022 The wait counter SHALL be wide enough for 15000*US_CYCLES without wrap; the byte index SHALL saturate at 33 and never wrap within a frame.
REQ-023 Each command byte in REQ-016 and REQ-018 SHALL appear on lcd_d exactly as the two nibbles of that value.

Reset
REQ-024 On rst assertion, asynchronously and regardless of state, the block SHALL:
- drive lcd_e=0, lcd_rs=0, lcd_d=0, ready=0;
- clear the pending flag, snapshot register and counters;
- enter PWR_WAIT.
REQ-025 After rst deasserts, the full PWR_WAIT and INIT sequence SHALL restart; no partial frame resumes, and no refresh is honoured before INIT ends except via the pending flag.

Verification (US_CYCLES=1, E_CYCLES=2)
REQ-026 Release rst -> lcd_e stays 0 for 15000 cycles; nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1 follows with rs=0; 1640-cycle gap after 0,1; ready=1 before the auto frame starts.
REQ-027 text = "12345678" x2 on line 0, "87654321" x2 on line 1, refresh in IDLE -> bytes 0x80, 0x31..0x38, 0x31..0x38, 0xC0, 0x38..0x31, 0x38..0x31; rs=1 exactly on char bytes.
REQ-028 Change text at byte index 5 mid-frame -> the remainder of the frame shows the old text; the next refresh shows the new text.
REQ-029 Three refresh pulses during a frame -> exactly one additional frame, ready stays low between the frames, then ready=1.
REQ-030 Assert rst during lcd_e=1 at index 20 -> lcd_e=0 and ready=0 in the same cycle; after release, 15000 cycles pass before the first lcd_e pulse.
REQ-031 Every nibble -> lcd_d/lcd_rs are stable from 2 cycles before lcd_e rises until 1 cycle after it falls, and lcd_e is high for exactly 2 cycles.
